ubcs_sub_seq_19_0: RTL and testbench
====================================

# ubcs_sub_seq_19_0

Sequential 20-bit carry-select add/subtract unit. It resolves one carry-select block per clock, using the same 1/1/2/3/4/5/4 block partition as the combinational carry-select adder family. Subtraction is X + ~Y + 1. It sits on the datapath as a handshaked, area-reduced arithmetic unit with a valid/ready interface on both sides, and is used where single-cycle 20-bit add latency is not required.

## Interface
- No parameters: operand width (20) and block partition ([0], [1], [3:2], [6:4], [10:7], [15:11], [19:16]) are fixed.
- CLK  input  1  clock; all state changes on rising edge.
- RSTn  input  1  reset, asynchronous assert, active-low.
- IV  input  1  operand valid.
- IRDY  output  1  ready to accept operands; 1 only in IDLE.
- X  input  20  operand 1; sampled on accept.
- Y  input  20  operand 2; sampled on accept.
- SUB  input  1  0: X+Y, 1: X−Y; sampled on accept.
- OVLD  output  1  result valid.
- ORDY  input  1  downstream ready.
- D  output  21  result. D[19:0] is the sum/difference mod 2^20. D[20] is the carry-out: for SUB=1, 1 means no borrow (X ≥ Y).

## Operation
- Accept: rising edge with IV=1 and IRDY=1. On accept:
  - latch X into XR.
  - latch Y into YR, inverted when SUB=1.
  - carry register C <= SUB.
  - block index K <= 0.
  - D <= 0.
  - go to RUN.
- States:
  - IDLE: IRDY=1, OVLD=0.
  - RUN: IRDY=0, OVLD=0, K=0..6.
  - DONE: IRDY=0, OVLD=1.
- RUN, each edge for block K = [hi:lo]:
  - form S0 = XR[hi:lo] + YR[hi:lo] + 0 and S1 = XR[hi:lo] + YR[hi:lo] + 1, each with its own block carry-out.
  - select S1 and its carry-out when C=1, else S0 and its carry-out.
  - D[hi:lo] <= selected sum; C <= selected carry-out; K <= K+1.
- RUN at K=6: D[19:16] written and D[20] <= selected carry-out on the same edge; go to DONE.
- DONE: D held stable. On an edge with ORDY=1, go to IDLE.
- IV while IRDY=0 is ignored; X, Y and SUB changes after accept have no effect.
- Only one block-sum datapath is instantiated, muxed by K; width is 5 bits plus carry.
- Reset (RSTn=0, any state, including mid-RUN): immediately
  - state=IDLE, OVLD=0, D=0, C=0, K=0, XR=YR=0;
  - IRDY=1 while in reset and after release;
  - the in-flight operation is discarded with no output.

## Timing
- Accept at edge n. RUN edges n+1..n+7. OVLD=1 after edge n+7.
- Latency accept→OVLD: 7 cycles.
- With ORDY=1, DONE lasts 1 cycle; IDLE is reached after edge n+8 and the next accept is at edge n+9 at the earliest. Minimum issue interval: 9 cycles.
- ORDY low holds DONE indefinitely, with D and OVLD constant.
- D[hi:lo] for block K is final after edge n+1+K. D is meaningful only while OVLD=1.
- IRDY and OVLD are decoded directly from the state register, with no combinational path from inputs.

## Test plan
- X=0x00005, Y=0x00003, SUB=1 → OVLD after 7 cycles, D=0x100002.
- X=0x00003, Y=0x00005, SUB=1 → D=0x0FFFFE (borrow: D[20]=0).
- X=0xFFFFF, Y=0x00001, SUB=0 → D=0x100000. This exercises full carry propagation through all 7 blocks; check D per block at each RUN edge.
- X=0x80000, Y=0x80000, SUB=1 → D=0x100000. Then X=0xFFFFF, Y=0xFFFFF, SUB=0 → D=0x1FFFFE.
- Backpressure: ORDY=0 for 5 cycles in DONE → D and OVLD stable. Hold IV=1 throughout → IRDY=0, no new accept. Raise ORDY → IDLE after the next edge, then accept the next op 1 cycle later.
- Drop RSTn during RUN at K=3 → OVLD=0, D=0, IRDY=1 immediately. After release, X=0x12345, Y=0x02345, SUB=1 → D=0x110000.

Source files
------------

// File: rtl/ubcs_sub_seq_19_0.sv
// rtl/ubcs_sub_seq_19_0.sv - sequential 20-bit carry-select add/subtract, one block per clock
module ubcs_sub_seq_19_0 (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        IV,
    output logic        IRDY,
    input  logic [19:0] X,
    input  logic [19:0] Y,
    input  logic        SUB,
    output logic        OVLD,
    input  logic        ORDY,
    output logic [20:0] D
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] xr_q, xr_d;
    logic [19:0] yr_q, yr_d;
    logic        c_q, c_d;
    logic [2:0]  k_q, k_d;
    logic [20:0] d_q, d_d;

    // Block partition 1/1/2/3/4/5/4 selected by the block index
    logic [4:0]  blk_lo;
    logic [2:0]  blk_w;
    logic [5:0]  mask6;
    logic [4:0]  blk_mask;
    logic [19:0] x_sh, y_sh;
    logic [4:0]  xb, yb;
    logic [5:0]  s0, s1, sel;
    logic        blk_co;
    logic [20:0] wr_mask, wr_val, d_blk;

    always_comb begin
        blk_lo = 5'd16;
        blk_w  = 3'd4;
        case (k_q)
            3'd0: begin blk_lo = 5'd0;  blk_w = 3'd1; end
            3'd1: begin blk_lo = 5'd1;  blk_w = 3'd1; end
            3'd2: begin blk_lo = 5'd2;  blk_w = 3'd2; end
            3'd3: begin blk_lo = 5'd4;  blk_w = 3'd3; end
            3'd4: begin blk_lo = 5'd7;  blk_w = 3'd4; end
            3'd5: begin blk_lo = 5'd11; blk_w = 3'd5; end
            default: begin blk_lo = 5'd16; blk_w = 3'd4; end
        endcase
    end

    // Single shared 5-bit block adder; both carry-in variants, then select on C
    always_comb begin
        mask6    = (6'd1 << blk_w) - 6'd1;
        blk_mask = mask6[4:0];
        x_sh     = xr_q >> blk_lo;
        y_sh     = yr_q >> blk_lo;
        xb       = x_sh[4:0] & blk_mask;
        yb       = y_sh[4:0] & blk_mask;
        s0       = {1'b0, xb} + {1'b0, yb};
        s1       = s0 + 6'd1;
        sel      = c_q ? s1 : s0;
        blk_co   = sel[blk_w];
        wr_mask  = {16'd0, blk_mask} << blk_lo;
        wr_val   = {16'd0, sel[4:0] & blk_mask} << blk_lo;
        d_blk    = (d_q & ~wr_mask) | wr_val;
    end

    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        c_d     = c_q;
        k_d     = k_q;
        d_d     = d_q;
        case (state_q)
            S_IDLE: begin
                if (IV) begin
                    xr_d    = X;
                    yr_d    = SUB ? ~Y : Y;
                    c_d     = SUB;
                    k_d     = 3'd0;
                    d_d     = 21'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                d_d = d_blk;
                c_d = blk_co;
                k_d = k_q + 3'd1;
                if (k_q == 3'd6) begin
                    d_d[20] = blk_co;
                    k_d     = 3'd0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ORDY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            xr_q    <= 20'd0;
            yr_q    <= 20'd0;
            c_q     <= 1'b0;
            k_q     <= 3'd0;
            d_q     <= 21'd0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            c_q     <= c_d;
            k_q     <= k_d;
            d_q     <= d_d;
        end
    end

    assign IRDY = (state_q == S_IDLE);
    assign OVLD = (state_q == S_DONE);
    assign D    = d_q;

endmodule

// File: tb/tb_ubcs_sub_seq_19_0.sv
// tb/tb_ubcs_sub_seq_19_0.sv - scoreboard bench for ubcs_sub_seq_19_0
module tb_ubcs_sub_seq_19_0;

    logic        CLK;
    logic        RSTn;
    logic        IV;
    logic        IRDY;
    logic [19:0] X;
    logic [19:0] Y;
    logic        SUB;
    logic        OVLD;
    logic        ORDY;
    logic [20:0] D;

    int n_cmp;
    int n_bad;
    logic [20:0] exp_q[$];

    ubcs_sub_seq_19_0 dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .IV   (IV),
        .IRDY (IRDY),
        .X    (X),
        .Y    (Y),
        .SUB  (SUB),
        .OVLD (OVLD),
        .ORDY (ORDY),
        .D    (D)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] model(input logic [19:0] x, input logic [19:0] y, input logic s);
        logic [19:0] yy;
        yy = s ? ~y : y;
        return {1'b0, x} + {1'b0, yy} + {20'd0, s};
    endfunction

    // Bits of D finalized after RUN step k (top block also carries D[20])
    function automatic logic [20:0] prefix_mask(input int k);
        int hi_tab[7] = '{0, 1, 3, 6, 10, 15, 19};
        if (k >= 6) return 21'h1FFFFF;
        return (21'd1 << (hi_tab[k] + 1)) - 21'd1;
    endfunction

    // Scoreboard consumer: compare on each output handshake
    always @(negedge CLK) begin
        if (RSTn && OVLD && ORDY) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(D), 32'h0BAD0BAD);
            end else begin
                chk("result", 32'(D), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic run_op(input logic [19:0] x, input logic [19:0] y, input logic s, input int hold);
        logic [20:0] e;
        e = model(x, y, s);
        X = x; Y = y; SUB = s; IV = 1'b1;
        ORDY = (hold == 0);
        chk("irdy_before_accept", 32'(IRDY), 32'd1);
        exp_q.push_back(e);
        @(posedge CLK); #1;
        X = ~x; Y = ~y; SUB = ~s;
        IV = (hold != 0);
        chk("irdy_in_run", 32'(IRDY), 32'd0);
        for (int k = 0; k < 7; k++) begin
            @(posedge CLK); #1;
            chk($sformatf("d_prefix_k%0d", k), 32'(D & prefix_mask(k)), 32'(e & prefix_mask(k)));
            chk($sformatf("ovld_k%0d", k), 32'(OVLD), (k == 6) ? 32'd1 : 32'd0);
        end
        if (hold != 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge CLK); #1;
                chk("hold_ovld", 32'(OVLD), 32'd1);
                chk("hold_d", 32'(D), 32'(e));
                chk("hold_irdy", 32'(IRDY), 32'd0);
            end
            IV = 1'b0;
            ORDY = 1'b1;
        end
        @(posedge CLK); #1;
        chk("irdy_after_done", 32'(IRDY), 32'd1);
        chk("ovld_after_done", 32'(OVLD), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        RSTn = 1'b0; IV = 1'b0; X = '0; Y = '0; SUB = 1'b0; ORDY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_irdy", 32'(IRDY), 32'd1);
        chk("rst_ovld", 32'(OVLD), 32'd0);
        chk("rst_d", 32'(D), 32'd0);
        RSTn = 1'b1;
        @(posedge CLK); #1;

        run_op(20'h00005, 20'h00003, 1'b1, 0);
        chk("const_5m3", 32'(model(20'h00005, 20'h00003, 1'b1)), 32'h100002);
        run_op(20'h00003, 20'h00005, 1'b1, 0);
        run_op(20'hFFFFF, 20'h00001, 1'b0, 0);
        run_op(20'h80000, 20'h80000, 1'b1, 0);
        run_op(20'hFFFFF, 20'hFFFFF, 1'b0, 5);
        run_op(20'h0ABCD, 20'h01234, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            run_op(20'($urandom), 20'($urandom), 1'($urandom), (i == 2) ? 2 : 0);
        end

        // Reset mid-RUN at K=3: in-flight result discarded
        X = 20'h11111; Y = 20'h22222; SUB = 1'b0; IV = 1'b1; ORDY = 1'b1;
        @(posedge CLK); #1;
        IV = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RSTn = 1'b0;
        #1;
        chk("midrun_rst_ovld", 32'(OVLD), 32'd0);
        chk("midrun_rst_d", 32'(D), 32'd0);
        chk("midrun_rst_irdy", 32'(IRDY), 32'd1);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        @(posedge CLK); #1;
        run_op(20'h12345, 20'h02345, 1'b1, 0);

        repeat (2) @(posedge CLK);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
